rom_port_arbiter: RTL and testbench

Shares the single synchronous port of the instruction/data ROM (block RAM with write port) between two read requesters and one write requester (program loader). Arbitrates every cycle, registers the winning command onto the RAM port, and returns read data with a fixed two-cycle latency tagged back to the requester. Sits between the processor fetch/data paths and the ROM instance in the processor top level.

---
 rtl/rom_arb_pkg.sv | 30 +++
 rtl/rr_arbiter2.sv | 69 ++++++
 rtl/rom_port_arbiter.sv | 121 ++++++++++++
 tb/tb_rom_port_arbiter.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/rom_arb_pkg.sv
// Shared types for the ROM port arbiter: command tag encoding and read latency.
package rom_arb_pkg;

    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_RD0  = 2'd1,
        TAG_RD1  = 2'd2,
        TAG_WR   = 2'd3
    } tag_e;

    localparam int READ_LATENCY = 2;

    // Tag of the command granted this cycle; the loader always outranks reads.
    function automatic tag_e encode_tag(input logic wr_gnt,
                                        input logic rd0_gnt,
                                        input logic rd1_gnt);
        tag_e tag;
        if (wr_gnt) begin
            tag = TAG_WR;
        end else if (rd0_gnt) begin
            tag = TAG_RD0;
        end else if (rd1_gnt) begin
            tag = TAG_RD1;
        end else begin
            tag = TAG_NONE;
        end
        return tag;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester read grant logic. Round-robin with ROM_ARB_RR_EN defined,
// fixed priority (port 0 first, no pointer state) otherwise.
module rr_arbiter2 (
`ifdef ROM_ARB_RR_EN
    input  logic clk,
    input  logic rst_n,
`endif
    input  logic enable,
    input  logic req0,
    input  logic req1,
    output logic gnt0,
    output logic gnt1
);

`ifdef ROM_ARB_RR_EN
    logic ptr_r;
    logic gnt0_s;
    logic gnt1_s;

    // ptr_r high means port 1 wins a tie.
    always_comb begin
        gnt0_s = 1'b0;
        gnt1_s = 1'b0;
        if (enable) begin
            gnt0_s = req0 & (~req1 | ~ptr_r);
            gnt1_s = req1 & (~req0 | ptr_r);
        end else begin
            gnt0_s = 1'b0;
            gnt1_s = 1'b0;
        end
    end

    // Pointer hands preference to the port that was not just served.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_r <= 1'b0;
        end else if (gnt0_s) begin
            ptr_r <= 1'b1;
        end else if (gnt1_s) begin
            ptr_r <= 1'b0;
        end else begin
            ptr_r <= ptr_r;
        end
    end

    assign gnt0 = gnt0_s;
    assign gnt1 = gnt1_s;
`else
    logic gnt0_s;
    logic gnt1_s;

    // Port 0 (fetch) always wins over port 1.
    always_comb begin
        gnt0_s = 1'b0;
        gnt1_s = 1'b0;
        if (enable) begin
            gnt0_s = req0;
            gnt1_s = req1 & ~req0;
        end else begin
            gnt0_s = 1'b0;
            gnt1_s = 1'b0;
        end
    end

    assign gnt0 = gnt0_s;
    assign gnt1 = gnt1_s;
`endif

endmodule

// File: rtl/rom_port_arbiter.sv
// Shares the single ROM port between two readers and the program loader.
// Define ROM_ARB_RR_EN for round-robin between readers; default is fixed priority.
module rom_port_arbiter
    import rom_arb_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 12
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     rdReq0,
    input  logic [ADDRESS_WIDTH-1:0] rdAddr0,
    output logic                     rdGnt0,
    output logic                     rdValid0,
    input  logic                     rdReq1,
    input  logic [ADDRESS_WIDTH-1:0] rdAddr1,
    output logic                     rdGnt1,
    output logic                     rdValid1,
    output logic [DATA_WIDTH-1:0]    rdData,
    input  logic                     wrReq,
    input  logic [ADDRESS_WIDTH-1:0] wrAddr,
    input  logic [DATA_WIDTH-1:0]    wrData,
    output logic                     wrGnt,
    output logic [ADDRESS_WIDTH-1:0] memAddr,
    output logic [ADDRESS_WIDTH-1:0] memWriteAddr,
    output logic [DATA_WIDTH-1:0]    memDataIn,
    output logic                     memWEn,
    input  logic [DATA_WIDTH-1:0]    memDataOut
);

    logic                     wr_gnt_s;
    logic                     rd_enable_s;
    logic                     rd_gnt0_s;
    logic                     rd_gnt1_s;
    tag_e                     issue_tag_s;
    tag_e                     tag_s1_r;
    logic                     rd_valid0_r;
    logic                     rd_valid1_r;
    logic                     mem_wen_r;
    logic [ADDRESS_WIDTH-1:0] mem_addr_r;
    logic [ADDRESS_WIDTH-1:0] mem_write_addr_r;
    logic [DATA_WIDTH-1:0]    mem_data_in_r;

    // Loader outranks both readers; nothing is granted while reset is held.
    always_comb begin
        wr_gnt_s    = 1'b0;
        rd_enable_s = 1'b0;
        if (reset_n) begin
            wr_gnt_s    = wrReq;
            rd_enable_s = ~wrReq;
        end else begin
            wr_gnt_s    = 1'b0;
            rd_enable_s = 1'b0;
        end
    end

    rr_arbiter2 u_rd_arb (
`ifdef ROM_ARB_RR_EN
        .clk    (clk),
        .rst_n  (reset_n),
`endif
        .enable (rd_enable_s),
        .req0   (rdReq0),
        .req1   (rdReq1),
        .gnt0   (rd_gnt0_s),
        .gnt1   (rd_gnt1_s)
    );

    // Tag of the command entering the pipeline this cycle.
    always_comb begin
        issue_tag_s = encode_tag(wr_gnt_s, rd_gnt0_s, rd_gnt1_s);
    end

    // Register the winning command onto the RAM pins; idle cycles hold address/data.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_wen_r        <= 1'b0;
            mem_addr_r       <= {ADDRESS_WIDTH{1'b0}};
            mem_write_addr_r <= {ADDRESS_WIDTH{1'b0}};
            mem_data_in_r    <= {DATA_WIDTH{1'b0}};
        end else if (wr_gnt_s) begin
            mem_wen_r        <= 1'b1;
            mem_write_addr_r <= wrAddr;
            mem_data_in_r    <= wrData;
        end else if (rd_gnt0_s) begin
            mem_wen_r  <= 1'b0;
            mem_addr_r <= rdAddr0;
        end else if (rd_gnt1_s) begin
            mem_wen_r  <= 1'b0;
            mem_addr_r <= rdAddr1;
        end else begin
            mem_wen_r <= 1'b0;
        end
    end

    // Tag pipeline; stage 2 is kept decoded as the two valid flops since only
    // read tags have a consumer there. Reset drops every in-flight read.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tag_s1_r    <= TAG_NONE;
            rd_valid0_r <= 1'b0;
            rd_valid1_r <= 1'b0;
        end else begin
            tag_s1_r    <= issue_tag_s;
            rd_valid0_r <= (tag_s1_r == TAG_RD0);
            rd_valid1_r <= (tag_s1_r == TAG_RD1);
        end
    end

    assign rdGnt0       = rd_gnt0_s;
    assign rdGnt1       = rd_gnt1_s;
    assign wrGnt        = wr_gnt_s;
    assign rdValid0     = rd_valid0_r;
    assign rdValid1     = rd_valid1_r;
    assign rdData       = memDataOut;
    assign memWEn       = mem_wen_r;
    assign memAddr      = mem_addr_r;
    assign memWriteAddr = mem_write_addr_r;
    assign memDataIn    = mem_data_in_r;

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Directed bench for rom_port_arbiter with a registered-output RAM model.
module tb_rom_port_arbiter;
    import rom_arb_pkg::*;

    localparam int DW = 32;
    localparam int AW = 12;
`ifdef ROM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset_n;
    logic          rdReq0, rdReq1, wrReq;
    logic [AW-1:0] rdAddr0, rdAddr1, wrAddr;
    logic [DW-1:0] wrData;
    logic          rdGnt0, rdGnt1, wrGnt, rdValid0, rdValid1, memWEn;
    logic [DW-1:0] rdData, memDataIn, memDataOut;
    logic [AW-1:0] memAddr, memWriteAddr;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    rom_port_arbiter #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) dut (
        .clk(clk), .reset_n(reset_n),
        .rdReq0(rdReq0), .rdAddr0(rdAddr0), .rdGnt0(rdGnt0), .rdValid0(rdValid0),
        .rdReq1(rdReq1), .rdAddr1(rdAddr1), .rdGnt1(rdGnt1), .rdValid1(rdValid1),
        .rdData(rdData),
        .wrReq(wrReq), .wrAddr(wrAddr), .wrData(wrData), .wrGnt(wrGnt),
        .memAddr(memAddr), .memWriteAddr(memWriteAddr), .memDataIn(memDataIn),
        .memWEn(memWEn), .memDataOut(memDataOut)
    );

    logic [DW-1:0] ram [0:(1<<AW)-1];

    always @(posedge clk) begin
        if (memWEn) ram[memWriteAddr] <= memDataIn;
        else        memDataOut <= ram[memAddr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic load(input logic [AW-1:0] a, input logic [DW-1:0] d);
        wrReq = 1'b1; wrAddr = a; wrData = d;
        #1 check("load_gnt", {31'd0, wrGnt}, 32'd1);
        @(negedge clk);
    endtask

    initial begin
        int seen;
        int p;
        reset_n = 1'b0;
        rdReq0 = 1'b0; rdReq1 = 1'b0; wrReq = 1'b0;
        rdAddr0 = 12'h000; rdAddr1 = 12'h000; wrAddr = 12'h000; wrData = 32'h0;
        repeat (2) @(negedge clk);

        // Reset state and grant suppression while reset is held
        check("rst_wen",    {31'd0, memWEn}, 32'd0);
        check("rst_addr",   {20'd0, memAddr}, 32'd0);
        check("rst_waddr",  {20'd0, memWriteAddr}, 32'd0);
        check("rst_din",    memDataIn, 32'd0);
        check("rst_valid",  {30'd0, rdValid1, rdValid0}, 32'd0);
        rdReq0 = 1'b1; wrReq = 1'b1;
        #1 check("rst_gnt", {30'd0, rdGnt0, wrGnt}, 32'd0);
        rdReq0 = 1'b0; wrReq = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;

        // Preload RAM through the loader port
        load(12'h005, 32'hDEADBEEF);
        load(12'h001, 32'h000000A1);
        load(12'h002, 32'h000000A2);
        load(12'h100, 32'h11110000);
        load(12'h200, 32'h22220000);
        wrReq = 1'b0;
        repeat (2) @(negedge clk);

        // Single read, two-cycle latency
        rdReq0 = 1'b1; rdAddr0 = 12'h005;
        #1 check("sr_gnt", {29'd0, wrGnt, rdGnt1, rdGnt0}, 32'd1);
        @(negedge clk); rdReq0 = 1'b0;
        check("sr_addr",   {20'd0, memAddr}, 32'h005);
        check("sr_wen",    {31'd0, memWEn}, 32'd0);
        check("sr_early",  {31'd0, rdValid0}, 32'd0);
        @(negedge clk);
        check("sr_valid",  {30'd0, rdValid1, rdValid0}, 32'd1);
        check("sr_data",   rdData, 32'hDEADBEEF);
        @(negedge clk);
        check("sr_pulse",  {31'd0, rdValid0}, 32'd0);
        @(negedge clk);

        // Write outranks both reads
        wrReq = 1'b1; wrAddr = 12'h020; wrData = 32'h12345678;
        rdReq0 = 1'b1; rdAddr0 = 12'h001; rdReq1 = 1'b1; rdAddr1 = 12'h002;
        #1 check("wp_gnt", {29'd0, wrGnt, rdGnt1, rdGnt0}, 32'd4);
        @(negedge clk); wrReq = 1'b0;
        check("wp_wen",   {31'd0, memWEn}, 32'd1);
        check("wp_waddr", {20'd0, memWriteAddr}, 32'h020);
        check("wp_din",   memDataIn, 32'h12345678);
        #1 check("wp_rdgnt", {29'd0, wrGnt, rdGnt1, rdGnt0}, RR ? 32'd2 : 32'd1);
        @(negedge clk); rdReq0 = 1'b0; rdReq1 = 1'b0;
        check("wp_wen_off", {31'd0, memWEn}, 32'd0);
        check("wp_raddr",   {20'd0, memAddr}, RR ? 32'h002 : 32'h001);
        @(negedge clk);
        check("wp_valid", {30'd0, rdValid1, rdValid0}, RR ? 32'd2 : 32'd1);
        check("wp_data",  rdData, RR ? 32'h000000A2 : 32'h000000A1);
        repeat (2) @(negedge clk);

        // Read-after-write to the same address
        wrReq = 1'b1; wrAddr = 12'h0AB; wrData = 32'hCAFEF00D;
        #1 check("raw_wgnt", {31'd0, wrGnt}, 32'd1);
        @(negedge clk); wrReq = 1'b0; rdReq1 = 1'b1; rdAddr1 = 12'h0AB;
        #1 check("raw_rgnt", {30'd0, rdGnt1, rdGnt0}, 32'd2);
        @(negedge clk); rdReq1 = 1'b0;
        @(negedge clk);
        check("raw_valid", {30'd0, rdValid1, rdValid0}, 32'd2);
        check("raw_data",  rdData, 32'hCAFEF00D);
        repeat (2) @(negedge clk);

        // Reset with a read in flight
        rdReq0 = 1'b1; rdAddr0 = 12'h010;
        #1 check("mr_gnt", {31'd0, rdGnt0}, 32'd1);
        @(negedge clk); reset_n = 1'b0;
        #1;
        check("mr_addr",  {20'd0, memAddr}, 32'd0);
        check("mr_waddr", {20'd0, memWriteAddr}, 32'd0);
        check("mr_din",   memDataIn, 32'd0);
        check("mr_wen",   {31'd0, memWEn}, 32'd0);
        check("mr_gnt_rst", {31'd0, rdGnt0}, 32'd0);
        rdReq0 = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (rdValid0 || rdValid1) seen++;
        end
        check("mr_no_valid", seen, 32'd0);

        // Contention: both readers held four cycles
        for (int k = 0; k < 8; k++) begin
            rdReq0 = (k < 4); rdReq1 = (k < 4);
            rdAddr0 = 12'h100; rdAddr1 = 12'h200;
            #1;
            if (k < 4) begin
                p = RR ? (k % 2) : 0;
                check("ct_gnt", {30'd0, rdGnt1, rdGnt0}, (p == 1) ? 32'd2 : 32'd1);
            end
            if (k >= 2 && k < 6) begin
                p = RR ? ((k - 2) % 2) : 0;
                check("ct_valid", {30'd0, rdValid1, rdValid0}, (p == 1) ? 32'd2 : 32'd1);
                check("ct_data",  rdData, (p == 1) ? 32'h22220000 : 32'h11110000);
            end
            @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
